// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants, state encoding and grant encoding for dmem_arb
package dmem_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam logic [31:0] DEF_HALT_ADDR = 32'h0000_7fff;

    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;
    localparam logic ENABLE_N  = 1'b0;
    localparam logic DISABLE_N = 1'b1;

    localparam logic RR_CPU  = 1'b0;
    localparam logic RR_HOST = 1'b1;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CPU  = 2'b01;
    localparam logic [1:0] GNT_HOST = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_HOST_BURST = 2'd1,
        ST_HALTED     = 2'd2
    } st_e;

endpackage

// File: rtl/dmem_arb_if.sv
// rtl/dmem_arb_if.sv - CPU, host and dmem signal bundle for dmem_arb
interface dmem_arb_if #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;
    logic              host_req;
    logic              host_we;
    logic [DATA_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_ack;
    logic [MEM_AW-1:0] mem_a;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;
    logic              halt;
    logic [DATA_W-1:0] halt_data;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  host_req, host_we, host_addr, host_wdata,
        output host_rdata, host_ack,
        output mem_a, mem_we, mem_wd,
        input  mem_rd,
        output halt, halt_data
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output host_req, host_we, host_addr, host_wdata,
        input  host_rdata, host_ack,
        input  mem_a, mem_we, mem_wd,
        output mem_rd,
        input  halt, halt_data
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - combinational grant decision from arbiter state and requests
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  st_e        st,
    input  logic       rr_last,
    input  logic [3:0] burst_cnt,
    input  logic       cpu_req,
    input  logic       host_req,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = GNT_NONE;
        case (st)
            ST_IDLE: begin
                // on a tie the side that did not win last goes first
                if (cpu_req && (!host_req || rr_last == RR_HOST))
                    gnt = GNT_CPU;
                else if (host_req)
                    gnt = GNT_HOST;
            end
            ST_HOST_BURST: begin
                if (host_req && (!cpu_req || burst_cnt < 4'(MAX_BURST)))
                    gnt = GNT_HOST;
                else if (cpu_req)
                    gnt = GNT_CPU;
            end
            ST_HALTED: begin
                if (host_req)
                    gnt = GNT_HOST;
            end
            default: gnt = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - CPU/host dmem arbiter with halt mailbox; DMEM_ARB_PERF_EN adds cycle/stall counters
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                MEM_AW    = 16,
    parameter int                MAX_BURST = 4,
    parameter logic [DATA_W-1:0] HALT_ADDR = DATA_W'(DEF_HALT_ADDR)
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_arb_if.slave  bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [DATA_W-1:0] cyc_cnt,
    output logic [DATA_W-1:0] stall_cnt
`endif
);

    st_e               st, st_nxt;
    logic              rr_last, rr_nxt;
    logic [3:0]        burst_cnt, burst_nxt;
    logic              halt_q, halt_nxt;
    logic [DATA_W-1:0] hdata_q, hdata_nxt;
    logic [1:0]        gnt_raw, gnt;
    logic              cpu_ack, host_ack, halt_hit;
    logic              unused_addr_bits;

    dmem_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .st        (st),
        .rr_last   (rr_last),
        .burst_cnt (burst_cnt),
        .cpu_req   (bus.cpu_req),
        .host_req  (bus.host_req),
        .gnt       (gnt_raw)
    );

    // no access may be acked while reset is held
    assign gnt      = (rst_n == DISABLE_N) ? gnt_raw : GNT_NONE;
    assign cpu_ack  = gnt[0];
    assign host_ack = gnt[1];
    assign halt_hit = cpu_ack & bus.cpu_we & (bus.cpu_addr == HALT_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == ENABLE_N) begin
            st        <= ST_IDLE;
            rr_last   <= RR_HOST;
            burst_cnt <= 4'd0;
            halt_q    <= DISABLE;
            hdata_q   <= '0;
        end else begin
            st        <= st_nxt;
            rr_last   <= rr_nxt;
            burst_cnt <= burst_nxt;
            halt_q    <= halt_nxt;
            hdata_q   <= hdata_nxt;
        end
    end

    always_comb begin
        st_nxt    = st;
        rr_nxt    = rr_last;
        burst_nxt = burst_cnt;
        halt_nxt  = halt_q;
        hdata_nxt = hdata_q;
        case (st)
            ST_IDLE: begin
                if (host_ack) begin
                    st_nxt    = ST_HOST_BURST;
                    burst_nxt = 4'd1;
                end else if (cpu_ack) begin
                    rr_nxt = RR_CPU;
                end
            end
            ST_HOST_BURST: begin
                if (host_ack) begin
                    if (burst_cnt != 4'hf)
                        burst_nxt = burst_cnt + 4'd1;
                end else begin
                    st_nxt = ST_IDLE;
                    rr_nxt = cpu_ack ? RR_CPU : RR_HOST;
                end
            end
            default: ;
        endcase
        if (halt_hit) begin
            st_nxt    = ST_HALTED;
            halt_nxt  = ENABLE;
            hdata_nxt = bus.cpu_wdata;
        end
    end

    // upper address bits are dropped so addresses wrap within dmem
    assign bus.mem_a  = host_ack ? bus.host_addr[MEM_AW+1:2] : bus.cpu_addr[MEM_AW+1:2];
    assign bus.mem_we = host_ack ? bus.host_we : (cpu_ack & bus.cpu_we & ~halt_hit);
    assign bus.mem_wd = host_ack ? bus.host_wdata : bus.cpu_wdata;

    assign bus.cpu_rdata  = cpu_ack  ? bus.mem_rd : '0;
    assign bus.host_rdata = host_ack ? bus.mem_rd : '0;
    assign bus.cpu_ack    = cpu_ack;
    assign bus.host_ack   = host_ack;
    assign bus.cpu_stall  = bus.cpu_req & ~cpu_ack;
    assign bus.halt       = halt_q;
    assign bus.halt_data  = hdata_q;

    assign unused_addr_bits = ^{bus.host_addr[DATA_W-1:MEM_AW+2], bus.host_addr[1:0]};

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == ENABLE_N) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
        end else if (!halt_q) begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (bus.cpu_stall)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arb.sv
// tb/tb_dmem_arb.sv - scoreboard bench for dmem_arb against a cycle-level arbitration model
module tb_dmem_arb;
    import dmem_arb_pkg::*;

    localparam int          DW    = 32;
    localparam int          AW    = 16;
    localparam int          MAXB  = 4;
    localparam logic [31:0] HADDR = 32'h0000_7fff;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arb_if #(.DATA_W(DW), .MEM_AW(AW)) bus ();

`ifdef DMEM_ARB_PERF_EN
    logic [DW-1:0] cyc_cnt, stall_cnt;
`endif

    dmem_arb #(.DATA_W(DW), .MEM_AW(AW), .MAX_BURST(MAXB), .HALT_ADDR(HADDR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef DMEM_ARB_PERF_EN
        ,
        .cyc_cnt   (cyc_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    logic [31:0] dmem    [0:65535];
    logic [31:0] ref_mem [0:65535];

    assign bus.mem_rd = dmem[bus.mem_a];
    always @(posedge clk) if (bus.mem_we) dmem[bus.mem_a] <= bus.mem_wd;

    typedef struct {
        logic        cpu_ack, host_ack, mem_we, halt, stall;
        logic [15:0] mem_a;
        logic [31:0] cpu_rdata, host_rdata, halt_data, cyc, stc;
    } exp_t;
    exp_t sb[$];

    int n_vec  = 0;
    int n_miss = 0;

    // reference model: streak counts consecutive host wins, prefer_cpu breaks idle ties
    bit          m_halted;
    logic [31:0] m_hdata, m_cyc, m_stc;
    int          m_streak;
    bit          m_prefer_cpu;
    bit          m_cg, m_hg;

    task automatic model_reset();
        m_halted = 0; m_hdata = 0; m_cyc = 0; m_stc = 0;
        m_streak = 0; m_prefer_cpu = 1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.cpu_req = r; bus.cpu_we = w; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask

    task automatic drive_host(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.host_req = r; bus.host_we = w; bus.host_addr = a; bus.host_wdata = d;
    endtask

    // called right after inputs are driven at a falling edge; pushes expectation, advances model
    task automatic tick();
        exp_t        e;
        logic        hit;
        logic [15:0] idx;
        if (!rst_n) model_reset();
        m_cg = 0; m_hg = 0;
        if (rst_n) begin
            if (m_halted)                         m_hg = bus.host_req;
            else if (bus.cpu_req && !bus.host_req) m_cg = 1;
            else if (bus.host_req && !bus.cpu_req) m_hg = 1;
            else if (bus.cpu_req && bus.host_req) begin
                if (m_streak > 0) begin m_hg = (m_streak < MAXB); m_cg = !m_hg; end
                else begin m_cg = m_prefer_cpu; m_hg = !m_prefer_cpu; end
            end
        end
        hit          = m_cg && bus.cpu_we && (bus.cpu_addr == HADDR);
        idx          = m_hg ? bus.host_addr[17:2] : bus.cpu_addr[17:2];
        e.cpu_ack    = m_cg;
        e.host_ack   = m_hg;
        e.mem_a      = idx;
        e.mem_we     = m_hg ? bus.host_we : (m_cg && bus.cpu_we && !hit);
        e.cpu_rdata  = m_cg ? ref_mem[idx] : 32'h0;
        e.host_rdata = m_hg ? ref_mem[idx] : 32'h0;
        e.halt       = m_halted;
        e.halt_data  = m_hdata;
        e.stall      = bus.cpu_req && !m_cg;
        e.cyc        = m_cyc;
        e.stc        = m_stc;
        sb.push_back(e);
        if (rst_n) begin
            if (e.mem_we) ref_mem[idx] = m_hg ? bus.host_wdata : bus.cpu_wdata;
            if (!m_halted) begin
                m_cyc++;
                if (e.stall) m_stc++;
            end
            if (hit) begin m_halted = 1; m_hdata = bus.cpu_wdata; end
            if (m_hg) m_streak = (m_streak < 15) ? m_streak + 1 : 15;
            else if (m_cg) begin m_streak = 0; m_prefer_cpu = 0; end
            else begin
                if (m_streak > 0) m_prefer_cpu = 1;
                m_streak = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("cpu_ack",    {31'b0, bus.cpu_ack},   {31'b0, e.cpu_ack});
                chk("host_ack",   {31'b0, bus.host_ack},  {31'b0, e.host_ack});
                chk("cpu_stall",  {31'b0, bus.cpu_stall}, {31'b0, e.stall});
                chk("mem_we",     {31'b0, bus.mem_we},    {31'b0, e.mem_we});
                chk("mem_a",      {16'b0, bus.mem_a},     {16'b0, e.mem_a});
                chk("cpu_rdata",  bus.cpu_rdata,          e.cpu_rdata);
                chk("host_rdata", bus.host_rdata,         e.host_rdata);
                chk("halt",       {31'b0, bus.halt},      {31'b0, e.halt});
                chk("halt_data",  bus.halt_data,          e.halt_data);
`ifdef DMEM_ARB_PERF_EN
                chk("cyc_cnt",    cyc_cnt,                e.cyc);
                chk("stall_cnt",  stall_cnt,              e.stc);
`endif
            end
        end
    end

    initial begin
        int  hi, cyc;
        bit  cpu_done, cpu_pend, host_pend;
        for (int i = 0; i < 65536; i++) begin
            dmem[i]    = 32'h5a00_0000 ^ (i * 32'h0001_0003);
            ref_mem[i] = 32'h5a00_0000 ^ (i * 32'h0001_0003);
        end
        dmem[4] = 32'hdeadbeef; ref_mem[4] = 32'hdeadbeef;
        model_reset();
        drive_cpu(0, 0, 0, 0); drive_host(0, 0, 0, 0);
        @(negedge clk);
        tick(); tick();
        rst_n = 1'b1;

        // simultaneous first request after reset: CPU first, host next
        drive_cpu(1, 0, 32'h20, 0); drive_host(1, 0, 32'h30, 0); tick();
        drive_cpu(0, 0, 0, 0); tick();
        drive_host(0, 0, 0, 0); tick();

        // CPU-only read of the preloaded word
        drive_cpu(1, 0, 32'h10, 0); tick();
        drive_cpu(0, 0, 0, 0); tick();

        // host burst with CPU waiting from cycle 1
        hi = 0; cpu_done = 0; cyc = 0;
        while ((hi < 8 || !cpu_done) && cyc < 40) begin
            if (hi < 8) drive_host(1, 1, 32'h100 + 4 * hi, 32'hb000 + hi);
            else        drive_host(0, 0, 0, 0);
            if (cyc >= 1 && !cpu_done) drive_cpu(1, 0, 32'h100, 0);
            else                       drive_cpu(0, 0, 0, 0);
            tick();
            if (m_hg) hi++;
            if (m_cg) cpu_done = 1;
            cyc++;
        end
        drive_cpu(0, 0, 0, 0); drive_host(0, 0, 0, 0); tick();

        // aliasing through dropped upper address bits
        drive_host(1, 1, 32'h0004_0004, 32'h5); tick();
        drive_host(0, 0, 0, 0); drive_cpu(1, 0, 32'h4, 0); tick();
        drive_cpu(0, 0, 0, 0); tick();

        // reset in the middle of a host burst
        drive_host(1, 1, 32'h200, 32'h77); drive_cpu(1, 0, 32'h40, 0); tick(); tick();
        rst_n = 1'b0; tick(); tick();
        rst_n = 1'b1; drive_host(1, 0, 32'h200, 0); drive_cpu(1, 0, 32'h44, 0); tick();
        drive_cpu(0, 0, 0, 0); tick();
        drive_host(0, 0, 0, 0); tick();

        // halt mailbox: store swallowed, CPU frozen, host still served
        drive_cpu(1, 1, HADDR, 32'h2a); tick();
        drive_cpu(1, 0, 32'h8, 0); tick();
        drive_host(1, 0, 32'h104, 0); tick(); tick();
        drive_host(0, 0, 0, 0); drive_cpu(0, 0, 0, 0); tick();

        // randomized segments separated by resets
        for (int seg = 0; seg < 3; seg++) begin
            rst_n = 1'b0; drive_cpu(0, 0, 0, 0); drive_host(0, 0, 0, 0); tick();
            rst_n = 1'b1;
            cpu_pend = 0; host_pend = 0;
            for (int c = 0; c < 400; c++) begin
                if (!cpu_pend) begin
                    if ($urandom_range(0, 2) != 0) begin
                        cpu_pend = 1;
                        if ($urandom_range(0, 299) == 0)
                            drive_cpu(1, 1, HADDR, $urandom);
                        else
                            drive_cpu(1, 1'($urandom), ($urandom_range(0, 63) << 2) | ($urandom_range(0, 3) << 18), $urandom);
                    end else drive_cpu(0, 0, 0, 0);
                end
                if (!host_pend) begin
                    if ($urandom_range(0, 2) != 0) begin
                        host_pend = 1;
                        drive_host(1, 1'($urandom), ($urandom_range(0, 63) << 2) | ($urandom_range(0, 3) << 18), $urandom);
                    end else drive_host(0, 0, 0, 0);
                end
                tick();
                if (m_cg) cpu_pend = 0;
                if (m_hg) host_pend = 0;
            end
        end

        drive_cpu(0, 0, 0, 0); drive_host(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #3;
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
